// File: rtl/kitt_scanner_pwm.sv
// Knight-Rider LED scanner with per-LED PWM brightness and a fading tail.
// Bounce, wrap-up, wrap-down and hold modes at a programmable step rate.
module kitt_scanner_pwm #(
  parameter int N_LEDS     = 8,
  parameter int PRESCALE_W = 16,
  parameter int PWM_W      = 3,
  parameter int DECAY      = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [1:0]                mode,
  input  logic [PRESCALE_W-1:0]     speed,
  output logic [N_LEDS-1:0]         led,
  output logic [$clog2(N_LEDS)-1:0] pos,
  output logic                      dir,
  output logic                      step
);

  localparam int POS_W = $clog2(N_LEDS);
  localparam logic [POS_W-1:0] LAST = POS_W'(N_LEDS - 1);
  localparam logic [POS_W-1:0] PEN  = POS_W'(N_LEDS - 2);
  localparam logic [POS_W-1:0] ONE  = POS_W'(1);
  localparam logic [PWM_W-1:0] MAX  = {PWM_W{1'b1}};
  localparam logic [PWM_W-1:0] DEC  = PWM_W'(DECAY);

  typedef enum logic [1:0] {
    M_BOUNCE  = 2'd0,
    M_WRAP_UP = 2'd1,
    M_WRAP_DN = 2'd2,
    M_HOLD    = 2'd3
  } mode_e;

  logic [PRESCALE_W-1:0] pre_cnt;
  logic [PWM_W-1:0]      pwm_cnt;
  logic [PWM_W-1:0]      lvl [N_LEDS];
  logic                  tick;
  logic [POS_W-1:0]      pos_nx;
  logic                  dir_nx;
  logic                  hold;

  assign tick = en & (pre_cnt >= speed);
  assign hold = (mode_e'(mode) == M_HOLD);

  always_comb begin
    pos_nx = pos;
    dir_nx = dir;
    unique case (mode_e'(mode))
      M_BOUNCE: begin
        if (!dir) begin
          if (pos == LAST) begin
            pos_nx = PEN;
            dir_nx = 1'b1;
          end else begin
            pos_nx = pos + ONE;
          end
        end else begin
          if (pos == '0) begin
            pos_nx = ONE;
            dir_nx = 1'b0;
          end else begin
            pos_nx = pos - ONE;
          end
        end
      end
      M_WRAP_UP: begin
        dir_nx = 1'b0;
        pos_nx = (pos == LAST) ? '0 : pos + ONE;
      end
      M_WRAP_DN: begin
        dir_nx = 1'b1;
        pos_nx = (pos == '0) ? LAST : pos - ONE;
      end
      M_HOLD: begin
        pos_nx = pos;
        dir_nx = dir;
      end
      default: begin
        pos_nx = pos;
        dir_nx = dir;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
      pos     <= '0;
      dir     <= 1'b0;
      step    <= 1'b0;
    end else begin
      step <= tick;
      if (tick) begin
        pre_cnt <= '0;
      end else if (en) begin
        pre_cnt <= pre_cnt + 1'b1;
      end
      if (tick && !hold) begin
        pos <= pos_nx;
        dir <= dir_nx;
      end
    end
  end

  // The head is loaded at full level; everything else decays toward zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_LEDS; i++) begin
        lvl[i] <= '0;
      end
      lvl[0] <= MAX;
    end else if (tick && !hold) begin
      for (int i = 0; i < N_LEDS; i++) begin
        if (POS_W'(i) == pos_nx) begin
          lvl[i] <= MAX;
        end else begin
          lvl[i] <= (lvl[i] > DEC) ? lvl[i] - DEC : '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt <= '0;
      led     <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      for (int i = 0; i < N_LEDS; i++) begin
        led[i] <= en & ((lvl[i] > pwm_cnt) | (lvl[i] == MAX));
      end
    end
  end

endmodule

// File: tb/tb_kitt_scanner_pwm.sv
// Directed bench for kitt_scanner_pwm: scan, tail duty, modes,
// enable gating, speed change and asynchronous reset.
module tb_kitt_scanner_pwm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic [1:0] mode = 2'd0;
  logic [15:0] speed = 16'd3;
  logic [7:0] led;
  logic [2:0] pos;
  logic       dir;
  logic       step;

  int total = 0;
  int fails = 0;
  int cnt [8];
  int exp_duty [8] = '{1, 3, 5, 8, 0, 0, 0, 0};

  kitt_scanner_pwm dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .mode  (mode),
    .speed (speed),
    .led   (led),
    .pos   (pos),
    .dir   (dir),
    .step  (step)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_ticks(input int n);
    cyc(4 * n);
  endtask

  initial begin
    cyc(1);
    chk("rst_pos", pos, 0);
    chk("rst_dir", dir, 0);
    chk("rst_led", led, 0);
    chk("rst_step", step, 0);
    rst = 1'b0;

    cyc(3);
    chk("pre_step", step, 0);
    chk("pre_pos", pos, 0);
    cyc(1);
    chk("t1_step", step, 1);
    chk("t1_pos", pos, 1);
    chk("t1_dir", dir, 0);
    cyc(1);
    chk("t1_step_low", step, 0);
    chk("t2_head_led", led[1], 1);
    cyc(3);
    chk("t2_step", step, 1);
    chk("t2_pos", pos, 2);
    cyc(4);
    chk("t3_step", step, 1);
    chk("t3_pos", pos, 3);

    speed = 16'd20;
    for (int i = 0; i < 8; i++) cnt[i] = 0;
    for (int k = 0; k < 8; k++) begin
      cyc(1);
      for (int i = 0; i < 8; i++) cnt[i] += int'(led[i]);
    end
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("duty_led%0d", i), cnt[i], exp_duty[i]);
    end

    speed = 16'd3;
    cyc(1);
    chk("t4_late_step", step, 1);
    chk("t4_pos", pos, 4);
    run_ticks(3);
    chk("t7_pos", pos, 7);
    chk("t7_dir", dir, 0);
    run_ticks(1);
    chk("t8_pos", pos, 6);
    chk("t8_dir", dir, 1);
    run_ticks(6);
    chk("t14_pos", pos, 0);
    chk("t14_dir", dir, 1);
    run_ticks(1);
    chk("t15_pos", pos, 1);
    chk("t15_dir", dir, 0);

    run_ticks(6);
    chk("pre_wrap_pos", pos, 7);
    mode = 2'd1;
    run_ticks(1);
    chk("wrap_up_pos", pos, 0);
    chk("wrap_up_dir", dir, 0);
    mode = 2'd2;
    run_ticks(1);
    chk("wrap_dn_pos", pos, 7);
    chk("wrap_dn_dir", dir, 1);
    mode = 2'd3;
    run_ticks(1);
    chk("hold_pos_a", pos, 7);
    chk("hold_step_a", step, 1);
    run_ticks(1);
    chk("hold_pos_b", pos, 7);
    chk("hold_step_b", step, 1);

    mode = 2'd0;
    cyc(1);
    en = 1'b0;
    cyc(10);
    chk("dis_pos", pos, 7);
    chk("dis_led", led, 0);
    chk("dis_step", step, 0);
    en = 1'b1;
    cyc(2);
    chk("en_wait_step", step, 0);
    chk("en_wait_pos", pos, 7);
    cyc(1);
    chk("en_tick_step", step, 1);
    chk("en_tick_pos", pos, 6);
    chk("en_tick_dir", dir, 1);

    cyc(2);
    speed = 16'd0;
    cyc(1);
    chk("spd0_step_a", step, 1);
    chk("spd0_pos_a", pos, 5);
    cyc(1);
    chk("spd0_step_b", step, 1);
    chk("spd0_pos_b", pos, 4);
    cyc(1);
    chk("spd0_pos_c", pos, 3);
    cyc(8);
    chk("pre_arst_pos", pos, 5);

    #2;
    rst = 1'b1;
    #1;
    chk("arst_pos", pos, 0);
    chk("arst_led", led, 0);
    chk("arst_step", step, 0);
    chk("arst_dir", dir, 0);
    #1;
    rst = 1'b0;

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
